tty_arbiter: RTL and testbench
==============================

// Module: tty_arbiter
// PURPOSE
//  Shares the single VGA text-terminal write port (tty_write/tty_data/tty_busy)
//  between two requesters, e.g. the CPU and a boot/debug message source.
//  Holds one character in an output buffer and paces it into the terminal.
//  Line lock: a requester that starts a line owns the port until it writes
//  newline (8'h0A) or goes idle, so lines never interleave.
// PARAMETERS
//  IDLE_TIMEOUT  1024  lock released after this many owner cycles with no accepted write (>=2)
//  CNT_WIDTH     16    idle counter width; must hold IDLE_TIMEOUT-1
// PORTS
//  clk          in   1  system clock; all state on posedge
//  reset        in   1  synchronous, active-high
//  req0_write   in   1  requester 0 write strobe, held until accepted
//  req0_data    in   8  requester 0 character
//  req0_busy    out  1  requester 0: write not accepted this cycle
//  req1_write   in   1  requester 1 write strobe
//  req1_data    in   8  requester 1 character
//  req1_busy    out  1  requester 1: write not accepted this cycle
//  tty_write    out  1  one-cycle write pulse to the terminal
//  tty_data     out  8  character, valid while tty_write=1
//  tty_busy     in   1  terminal busy; rises at the earliest 1 cycle after a pulse
//  lock_active  out  1  line lock held
//  lock_owner   out  1  owner of the lock (valid when lock_active=1)
// BEHAVIOUR
//  - Accept: reqN write is accepted on an edge where reqN_write=1 and reqN_busy=0.
//    Accepted data goes to buf_data; buf_valid=1 from the next cycle.
//  - reqN_busy is combinational: 1 if reset, or buf_valid, or (lock_active and
//    lock_owner!=N), or N lost arbitration this cycle.
//  - Arbitration (unlocked, buffer empty): a sole writer wins. If both write,
//    the winner is ~last_grant; last_grant <= winner. Reset sets last_grant=1,
//    so req0 wins the first contention.
//  - Lock: an unlocked accept of a non-newline char sets lock_active=1 and
//    lock_owner=winner. An owner accept of 8'h0A clears lock_active at that edge.
//    Newline while unlocked is passed through and takes no lock.
//  - Idle counter: cleared on every owner accept and while unlocked. Increments
//    each locked cycle with no owner accept. At IDLE_TIMEOUT-1 the next edge
//    clears lock_active and the counter; both requesters may then compete.
//  - Output stage: tty_write = buf_valid & ~tty_busy & ~guard (combinational).
//    tty_data = buf_data. On a pulse cycle: buf_valid<=0, guard<=1 for exactly
//    one cycle, because terminal busy lags the pulse.
//    Latency: accept at edge t -> tty_write high in cycle t+1 if the terminal is idle.
//    Throughput: 1 char per 2 cycles at most.
//  - Buffer full: both busy=1. Owner priority is kept; no accept in the pulse
//    cycle itself, next accept 1 cycle later.
//  - Reset (including mid-transfer): buffered char is dropped. buf_valid=0,
//    guard=0, lock_active=0, lock_owner=0, counter=0, buf_data=0. Outputs:
//    tty_write=0, tty_data=0, both busy=1. A pulse already issued is not recalled.
// STRUCTURE
//  - Shared package tty_pkg: TTY_NEWLINE=8'h0A, TTY_DATA_W=8; keep arbiter
//    constants there for reuse by the vga tty and cpu.
//  - Sub-module tty_out_stage: buffer, guard and tty_write/tty_data generation,
//    with load/ready toward the arbiter. The arbiter core keeps grant, lock,
//    last_grant and the idle counter.
// TESTING
//  1 Single char: req0 writes 8'h41, tty idle -> tty_write=1, tty_data=8'h41
//    one cycle after accept; lock_active=1, lock_owner=0.
//  2 Contention after reset: both write in the same cycle (8'h41/8'h42) ->
//    req0 accepted, req1_busy=1. req0 sends 8'h0A -> unlock; req1's 8'h42
//    is output next.
//  3 Line lock: req0 sends "AB" with req1 writing throughout -> req1_busy=1
//    until req0's 8'h0A is accepted. Output order is 41,42,0A,then req1 char.
//  4 Idle timeout (IDLE_TIMEOUT=8): req0 sends 8'h41 then stops, req1 waits ->
//    lock released 8 cycles after the last accept; req1 accepted next cycle.
//  5 Backpressure: tty_busy held 1 for 20 cycles with buf_valid=1 -> no pulse
//    and both busy=1. On tty_busy fall, exactly one pulse, then a one-cycle guard.
//  6 Reset mid-line: lock held and buffer full, assert reset 1 cycle ->
//    tty_write=0, lock_active=0, buffer dropped, last_grant=1.

Source files
------------

// File: rtl/tty_pkg.sv
// Shared constants and types for the VGA text terminal and its write-port arbiter.
package tty_pkg;

  localparam int unsigned TTY_DATA_W       = 8;
  localparam int unsigned TTY_IDLE_TIMEOUT = 1024;
  localparam int unsigned TTY_CNT_W        = 16;

  typedef logic [TTY_DATA_W-1:0] tty_char_t;

  localparam tty_char_t TTY_NEWLINE = 8'h0A;

  typedef struct packed {
    logic      write;
    tty_char_t data;
  } tty_req_t;

  typedef enum logic [1:0] {
    LOCK_FREE = 2'd0,
    LOCK_OWN0 = 2'd1,
    LOCK_OWN1 = 2'd2
  } lock_state_e;

  function automatic logic is_newline(input tty_char_t c);
    return c == TTY_NEWLINE;
  endfunction

endpackage

// File: rtl/tty_out_stage.sv
// One-character output buffer that paces writes into the terminal.
// The guard cycle covers the lag between a write pulse and the terminal raising busy.
module tty_out_stage
  import tty_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_i,
  input  tty_char_t load_data_i,
  output logic      ready_o,
  input  logic      tty_busy_i,
  output logic      tty_write_o,
  output tty_char_t tty_data_o
);

  logic      buf_valid_q, buf_valid_d;
  tty_char_t buf_data_q, buf_data_d;
  logic      guard_q, guard_d;
  logic      pulse;

  assign pulse       = buf_valid_q & ~tty_busy_i & ~guard_q & ~reset;
  assign ready_o     = ~buf_valid_q & ~reset;
  assign tty_write_o = pulse;
  assign tty_data_o  = buf_data_q;

  // A load only happens with the buffer empty, so it never coincides with a pulse.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    guard_d     = pulse;
    if (pulse) begin
      buf_valid_d = 1'b0;
    end
    if (load_i) begin
      buf_valid_d = 1'b1;
      buf_data_d  = load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      guard_q     <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      guard_q     <= guard_d;
    end
  end

endmodule

// File: rtl/tty_arbiter.sv
// Two-requester arbiter for the terminal write port with a per-line lock,
// so a line started by one requester is never interleaved with the other.
module tty_arbiter
  import tty_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = TTY_IDLE_TIMEOUT,
  parameter int unsigned CNT_WIDTH    = TTY_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_write,
  input  logic [TTY_DATA_W-1:0] req0_data,
  output logic                  req0_busy,
  input  logic                  req1_write,
  input  logic [TTY_DATA_W-1:0] req1_data,
  output logic                  req1_busy,
  output logic                  tty_write,
  output logic [TTY_DATA_W-1:0] tty_data,
  input  logic                  tty_busy,
  output logic                  lock_active,
  output logic                  lock_owner
);

  localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_TIMEOUT - 1);

  lock_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic                 last_grant_q, last_grant_d;

  tty_req_t  req0, req1;
  logic      ready;
  logic      elig0, elig1;
  logic      grant0, grant1;
  logic      load;
  tty_char_t win_data;

  assign req0 = '{write: req0_write, data: req0_data};
  assign req1 = '{write: req1_write, data: req1_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOCK_FREE;
      idle_cnt_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration, lock transitions and idle-timeout counting.
  always_comb begin
    elig0        = ready & (state_q != LOCK_OWN1);
    elig1        = ready & (state_q != LOCK_OWN0);
    grant0       = req0.write & elig0 & (~(req1.write & elig1) | last_grant_q);
    grant1       = req1.write & elig1 & (~(req0.write & elig0) | ~last_grant_q);
    load         = grant0 | grant1;
    win_data     = grant1 ? req1.data : req0.data;
    state_d      = state_q;
    idle_cnt_d   = '0;
    last_grant_d = load ? grant1 : last_grant_q;
    case (state_q)
      LOCK_FREE: begin
        if (load && !is_newline(win_data)) begin
          state_d = grant1 ? LOCK_OWN1 : LOCK_OWN0;
        end
      end
      LOCK_OWN0, LOCK_OWN1: begin
        if (load) begin
          if (is_newline(win_data)) begin
            state_d = LOCK_FREE;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = LOCK_FREE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = LOCK_FREE;
    endcase
  end

  always_comb begin
    req0_busy   = ~elig0 | (req0.write & ~grant0);
    req1_busy   = ~elig1 | (req1.write & ~grant1);
    lock_active = (state_q != LOCK_FREE);
    lock_owner  = (state_q == LOCK_OWN1);
  end

  tty_out_stage u_out (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .load_data_i (win_data),
    .ready_o     (ready),
    .tty_busy_i  (tty_busy),
    .tty_write_o (tty_write),
    .tty_data_o  (tty_data)
  );

endmodule

// File: tb/tb_tty_arbiter.sv
// Bench for tty_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of buffer, lock and round-robin rules.
module tb_tty_arbiter;

  localparam int TO = 8;

  logic       clk;
  logic       reset;
  logic       req0_write, req1_write;
  logic [7:0] req0_data, req1_data;
  logic       req0_busy, req1_busy;
  logic       tty_write;
  logic [7:0] tty_data;
  logic       tty_busy;
  logic       lock_active, lock_owner;

  tty_arbiter #(.IDLE_TIMEOUT(TO), .CNT_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_write  (req0_write),
    .req0_data   (req0_data),
    .req0_busy   (req0_busy),
    .req1_write  (req1_write),
    .req1_data   (req1_data),
    .req1_busy   (req1_busy),
    .tty_write   (tty_write),
    .tty_data    (tty_data),
    .tty_busy    (tty_busy),
    .lock_active (lock_active),
    .lock_owner  (lock_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] out_log[$];
  int         out_cyc[$];
  int         acc0_cyc, acc1_cyc;

  // Reference state: one-slot buffer, guard flag, owner (-1 = unlocked).
  bit       m_bv, m_guard;
  bit [7:0] m_bd;
  int       m_owner, m_idle, m_last;
  bit       e_busy0, e_busy1, e_twr;
  int       e_win;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bv = 0; m_bd = 8'h00; m_guard = 0;
    m_owner = -1; m_idle = 0; m_last = 1;
  endtask

  task automatic model_comb();
    bit can0, can1, w0, w1;
    can0 = !reset && !m_bv && (m_owner != 1);
    can1 = !reset && !m_bv && (m_owner != 0);
    w0 = req0_write && can0;
    w1 = req1_write && can1;
    if (w0 && w1) e_win = 1 - m_last;
    else if (w0)  e_win = 0;
    else if (w1)  e_win = 1;
    else          e_win = -1;
    e_busy0 = !(w0 && e_win == 0);
    e_busy1 = !(w1 && e_win == 1);
    if (!req0_write) e_busy0 = !can0;
    if (!req1_write) e_busy1 = !can1;
    e_twr = !reset && m_bv && !tty_busy && !m_guard;
  endtask

  task automatic model_seq();
    bit [7:0] c;
    if (reset) begin
      model_reset();
      return;
    end
    m_guard = e_twr;
    if (e_twr) m_bv = 0;
    if (e_win >= 0) begin
      c = (e_win == 1) ? req1_data : req0_data;
      m_bv = 1; m_bd = c; m_last = e_win; m_idle = 0;
      if (m_owner < 0) begin
        if (c != 8'h0A) m_owner = e_win;
      end else if (c == 8'h0A) begin
        m_owner = -1;
      end
    end else if (m_owner >= 0) begin
      if (m_idle == TO - 1) begin
        m_owner = -1;
        m_idle  = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic drive_reqs();
    req0_write = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_write = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  // One clock cycle: predict, compare at the falling edge, advance model and DUT.
  task automatic step();
    bit a0, a1;
    model_comb();
    @(negedge clk);
    chk("req0_busy", 32'(req0_busy), 32'(e_busy0));
    chk("req1_busy", 32'(req1_busy), 32'(e_busy1));
    chk("tty_write", 32'(tty_write), 32'(e_twr));
    chk("tty_data", 32'(tty_data), 32'(m_bd));
    chk("lock_active", 32'(lock_active), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("lock_owner", 32'(lock_owner), 32'(m_owner == 1));
    if (tty_write === 1'b1) begin
      out_log.push_back(tty_data);
      out_cyc.push_back(cyc);
    end
    a0 = req0_write && !e_busy0;
    a1 = req1_write && !e_busy1;
    if (a0) acc0_cyc = cyc;
    if (a1) acc1_cyc = cyc;
    model_seq();
    @(posedge clk);
    #1;
    cyc++;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive_reqs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    tty_busy = 1'b0;
    reset    = 1'b1;
    drive_reqs();
    step();
    reset = 1'b0;
    out_log.delete();
    out_cyc.delete();
  endtask

  initial begin
    int gap;
    reset = 1'b1;
    tty_busy = 1'b0;
    req0_write = 1'b0; req0_data = 8'h00;
    req1_write = 1'b0; req1_data = 8'h00;
    acc0_cyc = 0; acc1_cyc = 0;
    model_reset();
    #1;
    chk("rst_busy0", 32'(req0_busy), 32'd1);
    chk("rst_busy1", 32'(req1_busy), 32'd1);
    chk("rst_tty_write", 32'(tty_write), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Single character with the terminal idle.
    q0.push_back(8'h41);
    drive_reqs();
    step();
    #1;
    chk("t1_write", 32'(tty_write), 32'd1);
    chk("t1_data", 32'(tty_data), 32'h41);
    chk("t1_lock", 32'(lock_active), 32'd1);
    chk("t1_owner", 32'(lock_owner), 32'd0);
    run(3);

    // Contention right after reset: req0 wins, then req1 after newline.
    do_reset();
    q0 = '{8'h41, 8'h0A};
    q1 = '{8'h42};
    drive_reqs();
    #1;
    chk("t2_busy0", 32'(req0_busy), 32'd0);
    chk("t2_busy1", 32'(req1_busy), 32'd1);
    run(8);
    chk("t2_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      chk("t2_c0", 32'(out_log[0]), 32'h41);
      chk("t2_c1", 32'(out_log[1]), 32'h0A);
      chk("t2_c2", 32'(out_log[2]), 32'h42);
    end

    // Line lock keeps the line together.
    do_reset();
    q0 = '{8'h41, 8'h42, 8'h0A};
    q1 = '{8'h43};
    drive_reqs();
    run(12);
    chk("t3_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      chk("t3_c0", 32'(out_log[0]), 32'h41);
      chk("t3_c1", 32'(out_log[1]), 32'h42);
      chk("t3_c2", 32'(out_log[2]), 32'h0A);
      chk("t3_c3", 32'(out_log[3]), 32'h43);
    end

    // Idle timeout: lock drops 8 cycles after the last accept.
    do_reset();
    q0 = '{8'h41};
    q1 = '{8'h43};
    drive_reqs();
    acc0_cyc = -100; acc1_cyc = -200;
    run(14);
    chk("t4_gap", 32'(acc1_cyc - acc0_cyc), 32'd9);

    // Backpressure: nothing while busy, then pulses two cycles apart.
    do_reset();
    tty_busy = 1'b1;
    q0 = '{8'h41, 8'h42};
    drive_reqs();
    run(20);
    chk("t5_held", 32'(out_log.size()), 32'd0);
    tty_busy = 1'b0;
    run(6);
    chk("t5_count", 32'(out_log.size()), 32'd2);
    gap = (out_cyc.size() == 2) ? out_cyc[1] - out_cyc[0] : 0;
    chk("t5_gap", 32'(gap), 32'd2);

    // Reset with a full buffer and a held lock.
    do_reset();
    tty_busy = 1'b1;
    q0 = '{8'h41, 8'h42};
    drive_reqs();
    run(3);
    chk("t6_locked", 32'(lock_active), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tty_busy = 1'b0;
    q0.delete();
    drive_reqs();
    #1;
    chk("t6_write", 32'(tty_write), 32'd0);
    chk("t6_lock", 32'(lock_active), 32'd0);
    chk("t6_busy0", 32'(req0_busy), 32'd0);
    out_log.delete();
    q0 = '{8'h51};
    q1 = '{8'h52};
    drive_reqs();
    run(6);
    chk("t6_count", 32'(out_log.size()), 32'd1);
    if (out_log.size() > 0) chk("t6_first", 32'(out_log[0]), 32'h51);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0)
        q0.push_back(($urandom_range(0, 5) == 0) ? 8'h0A : 8'(8'h41 + $urandom_range(0, 25)));
      if (q1.size() == 0 && $urandom_range(0, 2) == 0)
        q1.push_back(($urandom_range(0, 5) == 0) ? 8'h0A : 8'(8'h61 + $urandom_range(0, 25)));
      tty_busy = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      drive_reqs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
